operand_fetch_stage: RTL

- Decode-to-execute pipeline stage that sits directly downstream of the register file.
- Drives the register file read addresses from the incoming decoded instruction and captures the returned operands into a pipeline register.
- Applies same-cycle writeback bypass so that operands reflect a write committed on the same edge.
- Keeps held operands coherent with writebacks that arrive while the stage is stalled, using a valid/ready handshake on both sides.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/operand_bypass.sv | 27 ++
 rtl/operand_fetch_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the decode/execute datapath: operand width,
// register index width, control bundle width and the hardwired zero register.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/operand_bypass.sv
// Resolves one source operand: x0 reads as zero, a same-cycle writeback to the
// requested register wins over the register file (or held) value.
module operand_bypass #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rfdata,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_writereg,
  input  logic [XLEN-1:0]   wb_writedata,
  output logic [XLEN-1:0]   operand
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(riscv_pkg::ZERO_REG);

  // x0 first, then writeback bypass, otherwise the supplied value
  always_comb begin
    operand = rfdata;
    if (rs == ZERO_IDX) begin
      operand = '0;
    end else if (wb_regwrite && (wb_writereg != ZERO_IDX) && (wb_writereg == rs)) begin
      operand = wb_writedata;
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch pipeline stage: drives register file read addresses, captures
// bypass-resolved operands, and keeps held operands coherent with writebacks
// that land while the stage is stalled.
// Optional: define OPERAND_FETCH_STALL_CNT_EN to add the stall_cycles counter.
module operand_fetch_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW,
  parameter int CTRL_W = riscv_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [REG_AW-1:0] in_rd,
  output logic [REG_AW-1:0] readreg1,
  output logic [REG_AW-1:0] readreg2,
  input  logic [XLEN-1:0]   readdata1,
  input  logic [XLEN-1:0]   readdata2,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_writereg,
  input  logic [XLEN-1:0]   wb_writedata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2
`ifdef OPERAND_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic            accept;
  logic            stalled;
  logic [XLEN-1:0] cap_op1;
  logic [XLEN-1:0] cap_op2;
  logic [XLEN-1:0] hold_op1;
  logic [XLEN-1:0] hold_op2;

  assign readreg1 = in_rs1;
  assign readreg2 = in_rs2;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign stalled  = out_valid && !out_ready;

  // Capture-time resolution of the incoming sources
  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_cap_op1 (
    .rs(in_rs1), .rfdata(readdata1), .wb_regwrite(wb_regwrite),
    .wb_writereg(wb_writereg), .wb_writedata(wb_writedata), .operand(cap_op1)
  );
  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_cap_op2 (
    .rs(in_rs2), .rfdata(readdata2), .wb_regwrite(wb_regwrite),
    .wb_writereg(wb_writereg), .wb_writedata(wb_writedata), .operand(cap_op2)
  );

  // Same match logic applied to the held operands; a held x0 source is
  // already zero, so re-resolving it is harmless
  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_hold_op1 (
    .rs(out_rs1), .rfdata(out_op1), .wb_regwrite(wb_regwrite),
    .wb_writereg(wb_writereg), .wb_writedata(wb_writedata), .operand(hold_op1)
  );
  operand_bypass #(.XLEN(XLEN), .REG_AW(REG_AW)) u_hold_op2 (
    .rs(out_rs2), .rfdata(out_op2), .wb_regwrite(wb_regwrite),
    .wb_writereg(wb_writereg), .wb_writedata(wb_writedata), .operand(hold_op2)
  );

  // Pipeline register: reset, then flush, then capture, then stall refresh
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_ctrl  <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_rd    <= '0;
      out_op1   <= '0;
      out_op2   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_ctrl  <= in_ctrl;
      out_rs1   <= in_rs1;
      out_rs2   <= in_rs2;
      out_rd    <= in_rd;
      out_op1   <= cap_op1;
      out_op2   <= cap_op2;
    end else if (stalled) begin
      out_op1   <= hold_op1;
      out_op2   <= hold_op2;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OPERAND_FETCH_STALL_CNT_EN
  // Free-running count of stalled cycles; wraps naturally, ignores flush
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stalled) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
